// File: rtl/usb_phy_pkg.sv
// Shared USB full-speed PHY definitions: line states, tx FSM states and
// protocol constants used by the transmit serializer and its NRZI stage.
package usb_phy_pkg;

    // Line states as {p, n}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_SYNC,
        TX_DATA,
        TX_EOP_SE0,
        TX_EOP_J
    } tx_state_e;

    localparam logic [7:0] SYNC_BYTE   = 8'h80;
    localparam logic [2:0] STUFF_LIMIT = 3'd6;

    function automatic logic [1:0] line_of(input logic level_j);
        return level_j ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_tx_nrzi_stuffer.sv
// NRZI encoder with bit stuffing: tracks the current differential level and
// the run of consecutive ones, and flags when the next bit time must be a stuff.
module usb_tx_nrzi_stuffer
    import usb_phy_pkg::*;
(
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic clear,
    input  logic strobe,
    input  logic bit_in,
    output logic level_next,
    output logic stall
);

    logic       level_j;
    logic [2:0] ones;

    assign stall      = (ones == STUFF_LIMIT);
    // A stuff bit is a forced 0, so it toggles exactly like a data 0
    assign level_next = (stall || !bit_in) ? ~level_j : level_j;

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            level_j <= 1'b1;
            ones    <= 3'd0;
        end else if (clear) begin
            level_j <= 1'b1;
            ones    <= 3'd0;
        end else if (strobe) begin
            level_j <= level_next;
            if (stall || !bit_in) begin
                ones <= 3'd0;
            end else if (ones != STUFF_LIMIT) begin
                ones <= ones + 3'd1;
            end
        end
    end

endmodule

// File: rtl/usb_fs_tx_serializer.sv
// Full-speed USB transmit serializer: SYNC, NRZI bit-stuffed payload and EOP
// toward the pad stage, fed bytewise over a valid/ready handshake.
//
// state      | meaning
// TX_IDLE    | line J, output disabled, waiting for tx_valid
// TX_SYNC    | sending SYNC byte 0x80
// TX_DATA    | sending payload bytes (plus stuff bits)
// TX_EOP_SE0 | two bit times of SE0
// TX_EOP_J   | one bit time of J, then back to idle
module usb_fs_tx_serializer
    import usb_phy_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_48mhz,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       usb_p_tx,
    output logic       usb_n_tx,
    output logic       usb_tx_en
);

    localparam int             TW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  T_MAX = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state;
    logic [TW-1:0] bit_timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shifter;

    logic bit_strobe;
    logic start;
    logic in_payload;
    logic send;
    logic send_bit;
    logic nrzi_clear;
    logic level_next;
    logic stall;

    assign bit_strobe = (bit_timer == T_MAX);
    assign start      = (state == TX_IDLE) && tx_valid;
    assign in_payload = (state == TX_SYNC) || (state == TX_DATA);
    assign nrzi_clear = !in_payload && !start;

    // Which bit (if any) the NRZI stage emits at this edge; shifter[0] is the bit now on the line
    always_comb begin
        send     = 1'b0;
        send_bit = 1'b0;
        if (start) begin
            send     = 1'b1;
            send_bit = SYNC_BYTE[0];
        end else if (in_payload && bit_strobe) begin
            if (stall) begin
                send = 1'b1;
            end else if (bit_idx != 3'd7) begin
                send     = 1'b1;
                send_bit = shifter[1];
            end else if (tx_valid) begin
                send     = 1'b1;
                send_bit = tx_data[0];
            end
        end
    end

    usb_tx_nrzi_stuffer u_nrzi (
        .clk_48mhz  (clk_48mhz),
        .reset_n    (reset_n),
        .clear      (nrzi_clear),
        .strobe     (send),
        .bit_in     (send_bit),
        .level_next (level_next),
        .stall      (stall)
    );

    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= TX_IDLE;
            bit_timer <= '0;
            bit_idx   <= 3'd0;
            shifter   <= 8'h00;
            tx_ready  <= 1'b0;
            tx_busy   <= 1'b0;
            usb_p_tx  <= 1'b1;
            usb_n_tx  <= 1'b0;
            usb_tx_en <= 1'b0;
        end else begin
            tx_ready  <= 1'b0;
            bit_timer <= (state == TX_IDLE || bit_strobe) ? '0 : bit_timer + 1'b1;
            case (state)
                TX_IDLE: begin
                    if (tx_valid) begin
                        state                  <= TX_SYNC;
                        shifter                <= SYNC_BYTE;
                        bit_idx                <= 3'd0;
                        {usb_p_tx, usb_n_tx}   <= line_of(level_next);
                        usb_tx_en              <= 1'b1;
                        tx_busy                <= 1'b1;
                    end
                end
                TX_SYNC, TX_DATA: begin
                    if (bit_strobe) begin
                        if (stall) begin
                            {usb_p_tx, usb_n_tx} <= line_of(level_next);
                        end else if (bit_idx != 3'd7) begin
                            shifter              <= shifter >> 1;
                            bit_idx              <= bit_idx + 3'd1;
                            {usb_p_tx, usb_n_tx} <= line_of(level_next);
                        end else if (tx_valid) begin
                            state                <= TX_DATA;
                            shifter              <= tx_data;
                            bit_idx              <= 3'd0;
                            tx_ready             <= 1'b1;
                            {usb_p_tx, usb_n_tx} <= line_of(level_next);
                        end else begin
                            // Underrun marks end of packet
                            state                <= TX_EOP_SE0;
                            bit_idx              <= 3'd0;
                            {usb_p_tx, usb_n_tx} <= LINE_SE0;
                        end
                    end
                end
                TX_EOP_SE0: begin
                    if (bit_strobe) begin
                        if (bit_idx == 3'd1) begin
                            state                <= TX_EOP_J;
                            {usb_p_tx, usb_n_tx} <= LINE_J;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end
                end
                TX_EOP_J: begin
                    if (bit_strobe) begin
                        state     <= TX_IDLE;
                        usb_tx_en <= 1'b0;
                        tx_busy   <= 1'b0;
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_fs_tx_serializer.sv
// Scoreboard bench for the USB FS transmit serializer: stimulus queues expected
// line symbols per bit time; a monitor samples mid-bit and compares.
module tb_usb_fs_tx_serializer;
    import usb_phy_pkg::*;

    logic       clk_48mhz = 1'b0;
    logic       reset_n   = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_ready, tx_busy, usb_p_tx, usb_n_tx, usb_tx_en;

    usb_fs_tx_serializer #(.CLKS_PER_BIT(4)) dut (
        .clk_48mhz (clk_48mhz),
        .reset_n   (reset_n),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .usb_p_tx  (usb_p_tx),
        .usb_n_tx  (usb_n_tx),
        .usb_tx_en (usb_tx_en)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk_48mhz) cyc++;

    logic [1:0] exp_sym_q[$];
    int         exp_len_q[$];
    int         exp_rdy_q[$];
    int         rdy_cyc[$];
    logic       mon_en = 1'b1;

    // Monitor: one sample per bit time at phase 1, end-of-packet bookkeeping on tx_en fall
    int   phase = 0, nbits = 0, nrdy = 0, ncyc = 0;
    logic en_d  = 1'b0;
    always @(negedge clk_48mhz) begin
        if (!mon_en) begin
            phase = 0; nbits = 0; nrdy = 0; ncyc = 0; en_d = 1'b0;
        end else begin
            if (tx_ready) nrdy++;
            if (usb_tx_en) begin
                ncyc++;
                if (phase == 1) begin
                    checks++;
                    if (exp_sym_q.size() == 0) begin
                        errors++;
                        $display("FAIL sym_extra bit %0d got p=%0b n=%0b, no symbol expected", nbits, usb_p_tx, usb_n_tx);
                    end else begin
                        logic [1:0] e;
                        e = exp_sym_q.pop_front();
                        if ({tx_busy, usb_p_tx, usb_n_tx} !== {1'b1, e}) begin
                            errors++;
                            $display("FAIL sym bit %0d got busy,p,n=%b%b%b want 1%b", nbits, tx_busy, usb_p_tx, usb_n_tx, e);
                        end
                    end
                    nbits++;
                end
                phase = (phase + 1) % 4;
            end else if (en_d) begin
                int el, er;
                el = (exp_len_q.size() != 0) ? exp_len_q.pop_front() : -1;
                er = (exp_rdy_q.size() != 0) ? exp_rdy_q.pop_front() : -1;
                checks++;
                if (nbits != el) begin
                    errors++;
                    $display("FAIL pkt_bits got %0d want %0d", nbits, el);
                end
                checks++;
                if (ncyc != 4 * el) begin
                    errors++;
                    $display("FAIL pkt_en_clocks got %0d want %0d", ncyc, 4 * el);
                end
                checks++;
                if (nrdy != er) begin
                    errors++;
                    $display("FAIL pkt_ready_pulses got %0d want %0d", nrdy, er);
                end
                checks++;
                if ({tx_busy, usb_p_tx, usb_n_tx} !== 3'b010) begin
                    errors++;
                    $display("FAIL idle_after_eop got busy,p,n=%b%b%b want 010", tx_busy, usb_p_tx, usb_n_tx);
                end
                phase = 0; nbits = 0; nrdy = 0; ncyc = 0;
            end
            en_d = usb_tx_en;
        end
    end

    task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    // Reference line encoding for a whole packet
    task automatic push_model(input logic [7:0] bytes[$]);
        logic       lvl;
        int         ones, n;
        logic [7:0] sb;
        logic [7:0] all[$];
        lvl = 1'b1; ones = 0; n = 0;
        all = bytes;
        all.push_front(SYNC_BYTE);
        foreach (all[i]) begin
            sb = all[i];
            for (int k = 0; k < 8; k++) begin
                if (sb[k]) ones++;
                else begin lvl = ~lvl; ones = 0; end
                exp_sym_q.push_back(lvl ? LINE_J : LINE_K); n++;
                if (ones == 6) begin
                    lvl = ~lvl; ones = 0;
                    exp_sym_q.push_back(lvl ? LINE_J : LINE_K); n++;
                end
            end
        end
        exp_sym_q.push_back(LINE_SE0);
        exp_sym_q.push_back(LINE_SE0);
        exp_sym_q.push_back(LINE_J);
        exp_len_q.push_back(n + 3);
        exp_rdy_q.push_back(bytes.size());
    endtask

    task automatic wait_ready();
        int t = 0;
        do begin @(negedge clk_48mhz); t++; end while (!tx_ready && t < 400);
        if (!tx_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout got no tx_ready want pulse within 400 clocks");
        end else begin
            rdy_cyc.push_back(cyc);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (tx_busy && t < 2000) begin @(negedge clk_48mhz); t++; end
        if (tx_busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout got tx_busy=1 want 0 within 2000 clocks");
        end
        repeat (3) @(negedge clk_48mhz);
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            tx_data  = bytes[i];
            tx_valid = 1'b1;
            wait_ready();
        end
        tx_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [1:0] ack_exp[19];
        int t;
        ack_exp = '{LINE_K, LINE_J, LINE_K, LINE_J, LINE_K, LINE_J, LINE_K, LINE_K,
                    LINE_J, LINE_J, LINE_K, LINE_J, LINE_J, LINE_K, LINE_K, LINE_K,
                    LINE_SE0, LINE_SE0, LINE_J};

        // Reset held with tx_valid high: idle outputs, then ACK starts right after release
        tx_valid = 1'b1;
        tx_data  = 8'hD2;
        repeat (4) @(negedge clk_48mhz);
        check_val("reset_outputs", {3'b000, usb_p_tx, usb_n_tx, usb_tx_en, tx_ready, tx_busy}, 8'b0001_0000);
        foreach (ack_exp[i]) exp_sym_q.push_back(ack_exp[i]);
        exp_len_q.push_back(19);
        exp_rdy_q.push_back(1);
        reset_n = 1'b1;
        @(negedge clk_48mhz);
        check_val("start_after_reset", {5'b0, usb_tx_en, usb_p_tx, usb_n_tx}, 8'b0000_0101);
        wait_ready();
        tx_valid = 1'b0;
        wait_idle();

        // Long run of ones: stuffing across a byte boundary
        q = '{8'hFF, 8'hFF};
        push_model(q); send_bytes(q); wait_idle();

        // Trailing stuff bit owed after the last data bit
        q = '{8'h00, 8'hFC};
        push_model(q); send_bytes(q); wait_idle();

        // Back-to-back bytes without stuffing: ready every 32 clocks
        rdy_cyc.delete();
        q = '{8'h55, 8'hAA, 8'h33};
        push_model(q); send_bytes(q); wait_idle();
        checks++;
        if (rdy_cyc.size() != 3 || rdy_cyc[1] - rdy_cyc[0] != 32 || rdy_cyc[2] - rdy_cyc[1] != 32) begin
            errors++;
            $display("FAIL ready_spacing got %0d pulses want 3 pulses 32 clocks apart", rdy_cyc.size());
        end

        // tx_valid during EOP is ignored; next packet starts as soon as IDLE is reached
        q = '{8'h3F};
        push_model(q); send_bytes(q);
        t = 0;
        while (!(usb_p_tx == 1'b0 && usb_n_tx == 1'b0) && t < 400) begin @(negedge clk_48mhz); t++; end
        check_val("reached_se0", {6'b0, usb_p_tx, usb_n_tx}, 8'h00);
        q = '{8'hC3};
        push_model(q);
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        wait_ready();
        tx_valid = 1'b0;
        wait_idle();

        // Abort mid-DATA: asynchronous reset forces J with output disabled
        mon_en   = 1'b0;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        repeat (45) @(negedge clk_48mhz);
        check_val("abort_in_packet", {7'b0, usb_tx_en}, 8'h01);
        @(posedge clk_48mhz);
        #2 reset_n = 1'b0;
        #1 check_val("abort_async", {5'b0, usb_p_tx, usb_n_tx, usb_tx_en}, 8'b0000_0100);
        tx_valid = 1'b0;
        repeat (10) @(negedge clk_48mhz);
        check_val("abort_held", {4'b0, usb_p_tx, usb_n_tx, usb_tx_en, tx_busy}, 8'b0000_1000);
        reset_n = 1'b1;
        repeat (20) @(negedge clk_48mhz);
        check_val("after_abort_idle", {4'b0, usb_p_tx, usb_n_tx, usb_tx_en, tx_busy}, 8'b0000_1000);
        mon_en = 1'b1;
        @(negedge clk_48mhz);

        // Clean packet after abort
        q = '{8'h4B};
        push_model(q); send_bytes(q); wait_idle();

        checks++;
        if (exp_sym_q.size() != 0 || exp_len_q.size() != 0) begin
            errors++;
            $display("FAIL leftover got %0d symbols %0d packets want 0", exp_sym_q.size(), exp_len_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
